// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Purpose:
//   Barrel shifter/rotator split into SHW = $clog2(WIDTH) register stages.
//   Stage k shifts or rotates by 2^k when bit k of the shift amount is set.
//   There is one result per cycle while the output is drained. The pipeline
//   freezes as a whole when the output beat is stalled.
//
// Configuration macro:
//   BARREL_SHIFTER_ARITH_EN - when defined, mode 2'b10 is an arithmetic
//                             shift (sign-filling right, logical left).
//                             When undefined, mode 2'b10 is a logical shift
//                             and no sign-fill logic is built.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   in_valid     in   input beat present
//   in_ready     out  input beat accepted this cycle (= ~stall)
//   mode         in   00 logical, 01 rotate, 10 arithmetic, 11 logical
//   direction    in   0 right, 1 left
//   shift_value  in   shift amount 0..WIDTH-1
//   din          in   operand
//   out_valid    out  result beat present
//   out_ready    in   downstream accepts result
//   dout         out  result
//
// Handshake: a beat moves on a rising edge when valid and ready are both
// high. stall = out_valid & ~out_ready. When the pipeline is stalled, every
// stage register holds its value. The input side sees in_ready low, so
// nothing is accepted. When there is no stall, all stages advance together.
// Empty stages (bubbles) are not collapsed.
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 mode,
    input  logic                       direction,
    input  logic [$clog2(WIDTH)-1:0]   shift_value,
    input  logic [WIDTH-1:0]           din,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout
);
    localparam int SHW = $clog2(WIDTH);

    // Valid and data are registered at every stage. The control fields
    // (mode, direction, shift bits) are only needed by a later stage, so the
    // last stage does not keep them.
    logic [SHW-1:0]             r_valid;
    logic [SHW-1:0][WIDTH-1:0]  r_data;
    logic [SHW-2:0][1:0]        r_mode;
    logic [SHW-2:0]             r_dir;
    logic [SHW-2:0][SHW-1:0]    r_sh;

    // Stage-input views: element 0 is the module input, element k is the
    // register after stage k-1.
    logic [SHW-1:0]             w_in_valid;
    logic [SHW-1:0][WIDTH-1:0]  w_in_data;
    logic [SHW-1:0][1:0]        w_in_mode;
    logic [SHW-1:0]             w_in_dir;
    logic [SHW-1:0][SHW-1:0]    w_in_sh;
    logic [SHW-1:0][WIDTH-1:0]  w_next_data;
    logic                       w_stall;
    logic                       w_unused_sh;

    // One stage: conditionally move d by amt positions.
    function automatic logic [WIDTH-1:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             dir,
        input logic             en,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            if (m == 2'b01) begin
                r = dir ? ((d << amt) | (d >> (WIDTH - amt)))
                        : ((d >> amt) | (d << (WIDTH - amt)));
            end
`ifdef BARREL_SHIFTER_ARITH_EN
            // The MSB is unchanged by every earlier arithmetic-right stage,
            // so the sign of the original operand is still in d[WIDTH-1].
            else if (m == 2'b10 && !dir) begin
                r = WIDTH'($signed(d) >>> amt);
            end
`endif
            else begin
                r = dir ? (d << amt) : (d >> amt);
            end
        end
        return r;
    endfunction

    always_comb begin
        w_in_valid[0] = in_valid;
        w_in_data[0]  = din;
        w_in_mode[0]  = mode;
        w_in_dir[0]   = direction;
        w_in_sh[0]    = shift_value;
        for (int k = 1; k < SHW; k++) begin
            w_in_valid[k] = r_valid[k-1];
            w_in_data[k]  = r_data[k-1];
            w_in_mode[k]  = r_mode[k-1];
            w_in_dir[k]   = r_dir[k-1];
            w_in_sh[k]    = r_sh[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            w_next_data[k] = stage_op(w_in_data[k], w_in_mode[k], w_in_dir[k],
                                      w_in_sh[k][k], 1 << k);
        end
    end

    // Stage k uses only bit k of the shift amount it carries. The other
    // bits go into this sink.
    assign w_unused_sh = ^w_in_sh;

    assign w_stall   = r_valid[SHW-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[SHW-1];
    assign dout      = r_data[SHW-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
            r_mode  <= '0;
            r_dir   <= '0;
            r_sh    <= '0;
        end else if (!w_stall) begin
            for (int k = 0; k < SHW; k++) begin
                r_valid[k] <= w_in_valid[k];
                // Payload loads only with a valid beat. A bubble does not
                // change data, so idle inputs cannot reach dout.
                if (w_in_valid[k]) begin
                    r_data[k] <= w_next_data[k];
                end
            end
            for (int k = 0; k < SHW - 1; k++) begin
                if (w_in_valid[k]) begin
                    r_mode[k] <= w_in_mode[k];
                    r_dir[k]  <= w_in_dir[k];
                    r_sh[k]   <= w_in_sh[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic             direction;
    logic [SHW-1:0]   shift_value;
    logic [W-1:0]     din;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     dout;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    bit rand_done;

    typedef struct {
        logic [W-1:0]   d;
        logic [1:0]     m;
        logic           dir;
        logic [SHW-1:0] sh;
        logic [W-1:0]   exp;
    } vec_t;

    vec_t tbl[$];

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .direction(direction), .shift_value(shift_value),
        .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m,
                                           input logic dir, input int sh);
        logic [2*W-1:0] dd;
        logic [W-1:0] r;
        if (m == 2'b01) begin
            dd = {d, d};
            if (dir) begin
                dd = dd << sh;
                r = dd[2*W-1:W];
            end else begin
                dd = dd >> sh;
                r = dd[W-1:0];
            end
        end else begin
            r = dir ? (d << sh) : (d >> sh);
`ifdef BARREL_SHIFTER_ARITH_EN
            if (m == 2'b10 && !dir) begin
                for (int i = 0; i < W; i++) r[i] = (i + sh < W) ? d[i + sh] : d[W-1];
            end
`endif
        end
        return r;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor. It samples on the falling edge, so a handshake seen
    // here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {56'd0, dout}, 64'hDEAD);
            end else begin
                check("dout", {56'd0, dout}, {56'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    // Call this just after a rising edge. It returns just after the edge that
    // accepts the beat, with in_valid still high.
    task automatic drive_beat(input logic [W-1:0] d, input logic [1:0] m,
                              input logic dir, input logic [SHW-1:0] sh,
                              input logic [W-1:0] exp);
        bit done = 0;
        din = d; mode = m; direction = dir; shift_value = sh; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        din = $urandom_range(0, (1 << W) - 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin @(posedge clk); #1; end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Measures latency from an acceptance to out_valid, with the pipeline
    // empty beforehand.
    task automatic latency_beat(input string name, input logic [W-1:0] d, input logic [1:0] m,
                                input logic dir, input logic [SHW-1:0] sh, input logic [W-1:0] exp);
        int lat;
        drive_beat(d, m, dir, sh, exp);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check(name, lat, SHW);
        drain();
    endtask

    // ---------------- main ----------------
    initial begin
        logic [W-1:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = '0; direction = 1'b0; shift_value = '0; din = '0;

        tbl.push_back('{8'hB1, 2'b01, 1'b1, 3'd3, 8'h8D});
        tbl.push_back('{8'hB1, 2'b00, 1'b0, 3'd4, 8'h0B});
        tbl.push_back('{8'hB1, 2'b00, 1'b1, 3'd4, 8'h10});
        tbl.push_back('{8'hB1, 2'b00, 1'b0, 3'd0, 8'hB1});
        tbl.push_back('{8'hB1, 2'b01, 1'b1, 3'd0, 8'hB1});
        tbl.push_back('{8'hB1, 2'b10, 1'b0, 3'd0, 8'hB1});
        tbl.push_back('{8'hB1, 2'b11, 1'b1, 3'd0, 8'hB1});
`ifdef BARREL_SHIFTER_ARITH_EN
        tbl.push_back('{8'hB1, 2'b10, 1'b0, 3'd2, 8'hEC});
`else
        tbl.push_back('{8'hB1, 2'b10, 1'b0, 3'd2, 8'h2C});
`endif
        tbl.push_back('{8'hB1, 2'b10, 1'b1, 3'd2, 8'hC4});
        tbl.push_back('{8'hB1, 2'b01, 1'b0, 3'd1, 8'hD8});
        tbl.push_back('{8'hB1, 2'b01, 1'b0, 3'd7, 8'h63});
        tbl.push_back('{8'hB1, 2'b11, 1'b1, 3'd1, 8'h62});
        tbl.push_back('{8'h71, 2'b10, 1'b0, 3'd3, 8'h0E});
        tbl.push_back('{8'h80, 2'b00, 1'b1, 3'd7, 8'h00});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // First acceptance right after reset, with the latency check
        latency_beat("latency_rotl", 8'hB1, 2'b01, 1'b1, 3'd3, 8'h8D);

        // Table vectors, back to back
        for (int i = 0; i < tbl.size(); i++)
            drive_beat(tbl[i].d, tbl[i].m, tbl[i].dir, tbl[i].sh, tbl[i].exp);
        drain();

        // Idle inputs must not produce beats
        idle(6);
        check("idle_no_valid", out_valid, 0);

        // 5 back-to-back beats, stalled 4 cycles once the first result shows
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [W-1:0] d;
                    d = 8'h11 * (i + 1);
                    drive_beat(d, 2'b01, 1'b0, 3'(i), model(d, 2'b01, 1'b0, i));
                end
                in_valid = 1'b0;
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                held = dout;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_dout_held", dout, held);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 3 beats in flight
        drive_beat(8'h5A, 2'b00, 1'b1, 3'd1, 8'hB4);
        drive_beat(8'h3C, 2'b01, 1'b1, 3'd2, 8'hF0);
        drive_beat(8'hC3, 2'b00, 1'b0, 3'd3, 8'h18);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_dout", dout, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        check("postrst_no_stale", out_valid, 0);
        latency_beat("latency_postrst", 8'hB1, 2'b00, 1'b0, 3'd4, 8'h0B);

        // Random traffic with random backpressure
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    logic [W-1:0] d;
                    logic [1:0] m;
                    logic dir;
                    logic [SHW-1:0] sh;
                    d = W'($urandom);
                    m = 2'($urandom_range(0, 3));
                    dir = 1'($urandom_range(0, 1));
                    sh = SHW'($urandom_range(0, W - 1));
                    drive_beat(d, m, dir, sh, model(d, m, dir, sh));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; power of two, 4 to 64.
REQ-002 Derived localparam: SHW = $clog2(WIDTH), shift-amount width and pipeline depth.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: in_valid  input  1  input beat present.
REQ-006 Port: in_ready  output  1  block accepts input beat this cycle.
REQ-007 Port: mode  input  2  00 logical shift, 01 rotate, 10 arithmetic shift, 11 reserved.
REQ-008 Port: direction  input  1  0 right, 1 left.
REQ-009 Port: shift_value  input  SHW  shift amount, 0 to WIDTH-1.
REQ-010 Port: din  input  WIDTH  operand.
REQ-011 Port: out_valid  output  1  result beat present.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: dout  output  WIDTH  result.

Function
REQ-014 Datapath SHALL be SHW stages; stage k conditionally shifts/rotates by 2^k using bit k of shift_value, followed by a register.
REQ-015 Each stage register SHALL carry valid, partial data, mode, direction and remaining shift bits.
REQ-016 Latency SHALL be exactly SHW cycles from accepted input (in_valid & in_ready) to out_valid, absent stalls.
REQ-017 Throughput SHALL be one beat per cycle when out_ready held high.
REQ-018 Stall = out_valid & ~out_ready; while stalled all stage registers SHALL hold.
REQ-019 in_ready SHALL equal ~stall (combinational from out_ready and out_valid).
REQ-020 Bubbles (invalid stages) SHALL advance whenever not stalled; no bubble collapsing required.
REQ-021 dout and out_valid SHALL remain stable while stalled; beats SHALL exit in acceptance order, none lost or duplicated.
REQ-022 Logical shift: vacated bits SHALL be 0, both directions.
REQ-023 Rotate: bits exiting one end SHALL enter the other; result = rotation by shift_value mod WIDTH.
REQ-024 Arithmetic right: vacated MSBs SHALL copy din[WIDTH-1]; arithmetic left SHALL equal logical left.
REQ-025 mode 11 SHALL behave as logical shift.
REQ-026 shift_value 0 SHALL pass din unchanged in every mode.
REQ-027 Inputs with in_valid low SHALL NOT affect dout or out_valid.

Reset
REQ-028 rst high SHALL immediately clear all stage valids, out_valid=0, dout=0, internal data registers=0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after rst deasserts.
REQ-030 in_ready SHALL be 1 during and after reset (out_valid=0).
REQ-031 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro BARREL_SHIFTER_ARITH_EN: when defined, mode 10 SHALL perform arithmetic shift per REQ-024.
REQ-033 When BARREL_SHIFTER_ARITH_EN undefined, mode 10 SHALL behave as logical shift and no sign-extension logic SHALL be synthesised; all other behaviour identical.

Verification (WIDTH=8)
REQ-034 Rotate left din=8'hB1, shift 3 -> dout=8'h8D, out_valid exactly 3 cycles after accept.
REQ-035 Logical right din=8'hB1, shift 4 -> 8'h0B; logical left 8'hB1 shift 4 -> 8'h10; shift 0 any mode -> 8'hB1.
REQ-036 Arithmetic right din=8'hB1, shift 2 -> 8'hEC with macro, 8'h2C without macro.
REQ-037 Back-to-back 5 beats, out_ready low 4 cycles once first result appears -> in_ready low, dout held, all 5 results in order, none lost.
REQ-038 Assert rst with 3 beats in flight -> out_valid=0, dout=0 at once; no stale beats after release; next beat correct after 3 cycles.
REQ-039 Random mode/direction/shift/din for 10k beats with random out_ready against a reference model -> zero mismatches, WIDTH in {4,8,32}.
